// File: rtl/mem_arbiter_2to1_pkg.sv
// mem_pkg: shared types and constants for the 2:1 memory arbiter.
//   state_t  - arbiter FSM states
//   GNT_*    - grant ids, also the bit positions in the one-hot grant vector
//   *_W      - default bus widths
package mem_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int MASK_W = 32;

   localparam logic GNT_IFU = 1'b0;
   localparam logic GNT_LSU = 1'b1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESP_IF = 2'd1,
      RESP_LS = 2'd2
   } state_t;

endpackage

// File: rtl/mem_arbiter_2to1_if.sv
// Bundle of the IFU, LSU and RAM-side handshake/bus signals.
//   slave  - the arbiter's view (requests and mem_rdata in; responses, readies
//            and memory strobes out)
//   master - the environment's view (requesters plus RAM wrapper)
interface mem_arbiter_2to1_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MASK_W = 32
) ();
   logic              ifu_req_valid;
   logic              ifu_req_ready;
   logic [ADDR_W-1:0] ifu_req_addr;
   logic              ifu_resp_valid;
   logic              ifu_resp_ready;
   logic [DATA_W-1:0] ifu_resp_rdata;

   logic              lsu_req_valid;
   logic              lsu_req_ready;
   logic              lsu_req_wen;
   logic [ADDR_W-1:0] lsu_req_addr;
   logic [MASK_W-1:0] lsu_req_wmask;
   logic [DATA_W-1:0] lsu_req_wdata;
   logic              lsu_resp_valid;
   logic              lsu_resp_ready;
   logic [DATA_W-1:0] lsu_resp_rdata;

   logic              mem_ren;
   logic [ADDR_W-1:0] mem_raddr;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_waddr;
   logic [MASK_W-1:0] mem_wmask;
   logic [DATA_W-1:0] mem_wdata;

   modport slave (
      input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
      input  lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wmask, lsu_req_wdata,
      input  lsu_resp_ready, mem_rdata,
      output ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
      output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
      output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wmask, mem_wdata
   );

   modport master (
      output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
      output lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wmask, lsu_req_wdata,
      output lsu_resp_ready, mem_rdata,
      input  ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
      input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
      input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wmask, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter_2to1_rr_arb2.sv
// rr_arb2: two-input round-robin grant.
//   i_valid      - request valids, bit GNT_IFU / bit GNT_LSU
//   i_last_grant - id of the most recently accepted requester
//   i_en         - grant enable (arbiter idle and out of reset)
//   o_gnt        - one-hot grant, zero when disabled or nothing requested
//   o_gnt_id     - id of the winner (only meaningful when o_gnt != 0)
module rr_arb2
   import mem_pkg::*;
(
   input  logic [1:0] i_valid,
   input  logic       i_last_grant,
   input  logic       i_en,
   output logic [1:0] o_gnt,
   output logic       o_gnt_id
);

   // On a tie the requester that did not go last wins; otherwise the lone
   // valid wins regardless of history.
   assign o_gnt_id = (&i_valid) ? ~i_last_grant : i_valid[GNT_LSU];
   assign o_gnt    = (i_en && (|i_valid)) ? (2'b01 << o_gnt_id) : 2'b00;

endmodule

// File: rtl/mem_arbiter_2to1.sv
// mem_arbiter_2to1: shares one single-issue memory port between the IFU
// (reads only) and the LSU (loads and stores). Round-robin grant, one
// transaction outstanding, one-cycle memory read latency.
//   clock, reset_n - clock and asynchronous active-low reset
//   bus            - IFU/LSU request+response handshakes and RAM port
module mem_arbiter_2to1
   import mem_pkg::*;
#(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W,
   parameter int MASK_W = mem_pkg::MASK_W
) (
   input  logic               clock,
   input  logic               reset_n,
   mem_arbiter_2to1_if.slave  bus
);

   state_t            r_state;
   logic              r_last_grant;
   logic              r_first;     // first response cycle: RAM data is live
   logic              r_is_store;  // response is a store ack
   logic [DATA_W-1:0] r_rdata_q;

   logic [1:0]        w_gnt;
   logic              w_gnt_id;
   logic              w_en;
   logic              w_ifu_acc;
   logic              w_lsu_rd;
   logic              w_lsu_st;
   logic              w_take;
   logic [DATA_W-1:0] w_resp_data;

   // Readies must stay low while reset is held, so the enable includes it.
   assign w_en = (r_state == IDLE) && reset_n;

   rr_arb2 u_rr_arb2 (
      .i_valid      ({bus.lsu_req_valid, bus.ifu_req_valid}),
      .i_last_grant (r_last_grant),
      .i_en         (w_en),
      .o_gnt        (w_gnt),
      .o_gnt_id     (w_gnt_id)
   );

   assign bus.ifu_req_ready = w_gnt[GNT_IFU];
   assign bus.lsu_req_ready = w_gnt[GNT_LSU];

   assign w_ifu_acc = w_gnt[GNT_IFU];
   assign w_lsu_rd  = w_gnt[GNT_LSU] & ~bus.lsu_req_wen;
   assign w_lsu_st  = w_gnt[GNT_LSU] &  bus.lsu_req_wen;

   // Memory side is driven straight from the accepted request; buses are
   // zeroed whenever their strobe is low.
   assign bus.mem_ren   = w_ifu_acc | w_lsu_rd;
   assign bus.mem_raddr = w_ifu_acc ? bus.ifu_req_addr :
                          w_lsu_rd  ? bus.lsu_req_addr : '0;
   assign bus.mem_wen   = w_lsu_st;
   assign bus.mem_waddr = w_lsu_st ? bus.lsu_req_addr  : '0;
   assign bus.mem_wmask = w_lsu_st ? bus.lsu_req_wmask : '0;
   assign bus.mem_wdata = w_lsu_st ? bus.lsu_req_wdata : '0;

   // RAM data is only valid in the first response cycle; afterwards the
   // captured copy is presented so a stalled response stays stable.
   assign w_resp_data = r_first ? (r_is_store ? '0 : bus.mem_rdata) : r_rdata_q;

   assign bus.ifu_resp_valid = (r_state == RESP_IF);
   assign bus.lsu_resp_valid = (r_state == RESP_LS);
   assign bus.ifu_resp_rdata = bus.ifu_resp_valid ? w_resp_data : '0;
   assign bus.lsu_resp_rdata = bus.lsu_resp_valid ? w_resp_data : '0;

   assign w_take = (bus.ifu_resp_valid & bus.ifu_resp_ready) |
                   (bus.lsu_resp_valid & bus.lsu_resp_ready);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_last_grant <= GNT_LSU;
         r_first      <= 1'b0;
         r_is_store   <= 1'b0;
         r_rdata_q    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|w_gnt) begin
                  r_state      <= (w_gnt_id == GNT_LSU) ? RESP_LS : RESP_IF;
                  r_last_grant <= w_gnt_id;
                  r_first      <= 1'b1;
                  r_is_store   <= w_lsu_st;
               end
            end
            RESP_IF, RESP_LS: begin
               r_first <= 1'b0;
               if (r_first) r_rdata_q <= w_resp_data;
               if (w_take)  r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Bench for mem_arbiter_2to1: directed scenarios followed by a randomized
// phase checked against a transaction-level model of the arbiter and RAM.
module tb_mem_arbiter_2to1;
   import mem_pkg::*;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   mem_arbiter_2to1_if #(.ADDR_W(32), .DATA_W(32), .MASK_W(32)) bus ();

   mem_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32), .MASK_W(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- RAM: either forced data or a small backing store -------
   logic        ram_auto     = 1'b0;
   logic [31:0] forced_rdata = '0;
   logic [31:0] ram_q;
   logic [31:0] ram [64];
   logic [63:0] ram_wr;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ram_wr <= '0;
         ram_q  <= '0;
      end else begin
         if (bus.mem_wen) begin
            ram[bus.mem_waddr[7:2]] <=
               ((ram_wr[bus.mem_waddr[7:2]] ? ram[bus.mem_waddr[7:2]] : dflt(bus.mem_waddr))
                & ~bus.mem_wmask) | (bus.mem_wdata & bus.mem_wmask);
            ram_wr[bus.mem_waddr[7:2]] <= 1'b1;
         end
         if (bus.mem_ren)
            ram_q <= ram_wr[bus.mem_raddr[7:2]] ? ram[bus.mem_raddr[7:2]] : dflt(bus.mem_raddr);
      end
   end

   assign bus.mem_rdata = ram_auto ? ram_q : forced_rdata;

   // ---------------- reference model state ---------------------------------
   logic [31:0] mdl [64];
   logic [63:0] mdl_wr;

   function automatic logic [31:0] mdl_rd(input logic [31:0] a);
      return mdl_wr[a[7:2]] ? mdl[a[7:2]] : dflt(a);
   endfunction

   task automatic idle_inputs();
      bus.ifu_req_valid  = 1'b0;
      bus.ifu_req_addr   = '0;
      bus.ifu_resp_ready = 1'b0;
      bus.lsu_req_valid  = 1'b0;
      bus.lsu_req_wen    = 1'b0;
      bus.lsu_req_addr   = '0;
      bus.lsu_req_wmask  = '0;
      bus.lsu_req_wdata  = '0;
      bus.lsu_resp_ready = 1'b0;
   endtask

   task automatic nxt();
      @(posedge clock);
      #1;
   endtask

   // random-phase state
   logic        ip, lp, lwen, m_last, busy, owner, g_vld, g;
   logic [31:0] ia, la, lm, ld, exp_data;

   initial begin
      idle_inputs();

      // ---- reset with both requesters waiting; IFU wins the first tie ----
      reset_n = 1'b0;
      bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0000;
      bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_0004;
      forced_rdata = 32'h0000_0413;
      #3;
      chk("rst_ifu_ready", bus.ifu_req_ready, 0);
      chk("rst_lsu_ready", bus.lsu_req_ready, 0);
      chk("rst_ren", bus.mem_ren, 0);
      chk("rst_wen", bus.mem_wen, 0);
      chk("rst_ifu_rvalid", bus.ifu_resp_valid, 0);
      chk("rst_lsu_rvalid", bus.lsu_resp_valid, 0);
      nxt(); nxt();
      reset_n = 1'b1;
      #3;
      chk("first_ifu_ready", bus.ifu_req_ready, 1);
      chk("first_lsu_ready", bus.lsu_req_ready, 0);
      chk("first_ren", bus.mem_ren, 1);
      chk("first_raddr", bus.mem_raddr, 32'h8000_0000);
      nxt();
      bus.ifu_req_valid = 1'b0; bus.ifu_resp_ready = 1'b1;
      #3;
      chk("first_ifu_rvalid", bus.ifu_resp_valid, 1);
      chk("first_ifu_rdata", bus.ifu_resp_rdata, 32'h0000_0413);
      chk("first_resp_lsu_ready", bus.lsu_req_ready, 0);
      nxt();

      // ---- both held valid: grants alternate, one accept per 2 cycles ----
      bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0010;
      bus.lsu_resp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #3;
         chk("alt_lsu_ready", bus.lsu_req_ready, (k % 2 == 0));
         chk("alt_ifu_ready", bus.ifu_req_ready, (k % 2 != 0));
         nxt();
         #3;
         chk("alt_resp_ifu_ready", bus.ifu_req_ready, 0);
         chk("alt_resp_lsu_ready", bus.lsu_req_ready, 0);
         chk("alt_resp_valid", (k % 2 == 0) ? bus.lsu_resp_valid : bus.ifu_resp_valid, 1);
         nxt();
      end
      bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
      nxt();

      // ---- LSU store ----
      bus.lsu_req_valid = 1'b1; bus.lsu_req_wen = 1'b1;
      bus.lsu_req_addr  = 32'h8000_1000;
      bus.lsu_req_wdata = 32'hDEAD_BEEF;
      bus.lsu_req_wmask = 32'hFFFF_FFFF;
      #3;
      chk("st_ready", bus.lsu_req_ready, 1);
      chk("st_wen", bus.mem_wen, 1);
      chk("st_waddr", bus.mem_waddr, 32'h8000_1000);
      chk("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      chk("st_wmask", bus.mem_wmask, 32'hFFFF_FFFF);
      chk("st_ren", bus.mem_ren, 0);
      chk("st_raddr", bus.mem_raddr, 0);
      nxt();
      bus.lsu_req_valid = 1'b0; bus.lsu_req_wen = 1'b0;
      forced_rdata = 32'h5555_5555;
      #3;
      chk("st_ack_valid", bus.lsu_resp_valid, 1);
      chk("st_ack_rdata", bus.lsu_resp_rdata, 0);
      chk("st_ack_wen", bus.mem_wen, 0);
      chk("st_ack_waddr", bus.mem_waddr, 0);
      nxt();

      // ---- LSU load with stalled response; IFU waits ----
      bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_0020;
      bus.lsu_resp_ready = 1'b0;
      #3;
      chk("ld_ready", bus.lsu_req_ready, 1);
      chk("ld_ren", bus.mem_ren, 1);
      nxt();
      bus.lsu_req_valid = 1'b0;
      bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0040;
      forced_rdata = 32'h1234_5678;
      #3;
      chk("ld_rvalid", bus.lsu_resp_valid, 1);
      chk("ld_rdata", bus.lsu_resp_rdata, 32'h1234_5678);
      chk("ld_ifu_blocked", bus.ifu_req_ready, 0);
      nxt();
      forced_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         #3;
         chk("stall_rvalid", bus.lsu_resp_valid, 1);
         chk("stall_rdata", bus.lsu_resp_rdata, 32'h1234_5678);
         chk("stall_ifu_blocked", bus.ifu_req_ready, 0);
         nxt();
      end
      bus.lsu_resp_ready = 1'b1;
      #3;
      chk("take_rdata", bus.lsu_resp_rdata, 32'h1234_5678);
      chk("take_ifu_blocked", bus.ifu_req_ready, 0);
      nxt();
      bus.lsu_resp_ready = 1'b0;
      #3;
      chk("after_ifu_ready", bus.ifu_req_ready, 1);
      chk("after_lsu_rvalid", bus.lsu_resp_valid, 0);
      chk("after_raddr", bus.mem_raddr, 32'h8000_0040);
      forced_rdata = 32'hCAFE_F00D;
      nxt();

      // ---- asynchronous reset in RESP_IF ----
      bus.ifu_req_valid = 1'b0; bus.ifu_resp_ready = 1'b0;
      #1;
      chk("pre_arst_rvalid", bus.ifu_resp_valid, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("arst_rvalid", bus.ifu_resp_valid, 0);
      bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1; bus.lsu_req_wen = 1'b0;
      nxt(); nxt();
      reset_n = 1'b1;
      #3;
      chk("arst_tie_ifu", bus.ifu_req_ready, 1);
      chk("arst_tie_lsu", bus.lsu_req_ready, 0);
      nxt();
      bus.ifu_req_valid = 1'b0; bus.ifu_resp_ready = 1'b1; bus.lsu_resp_ready = 1'b1;
      #3;
      chk("arst_resp", bus.ifu_resp_valid, 1);
      nxt();

      // ---- only LSU valid for 3 transactions ----
      for (int k = 0; k < 3; k++) begin
         #3;
         chk("solo_lsu_ready", bus.lsu_req_ready, 1);
         chk("solo_ifu_ready", bus.ifu_req_ready, 0);
         nxt();
         #3;
         chk("solo_lsu_rvalid", bus.lsu_resp_valid, 1);
         nxt();
      end

      // ---- randomized traffic against the transaction model ----
      idle_inputs();
      reset_n = 1'b0; ram_auto = 1'b1; mdl_wr = '0;
      nxt(); nxt();
      reset_n = 1'b1;
      ip = 0; lp = 0; lwen = 0; ia = 0; la = 0; lm = 0; ld = 0;
      m_last = GNT_LSU; busy = 0; owner = GNT_IFU; exp_data = 0;
      for (int c = 0; c < 1500; c++) begin
         if (!ip && $urandom_range(0, 2) == 0) begin
            ip = 1; ia = 32'($urandom_range(0, 63)) << 2;
         end
         if (!lp && $urandom_range(0, 2) == 0) begin
            lp = 1; lwen = 1'($urandom_range(0, 1));
            la = 32'($urandom_range(0, 63)) << 2;
            ld = $urandom;
            case ($urandom_range(0, 3))
               0: lm = 32'hFFFF_FFFF;
               1: lm = 32'h0000_00FF;
               2: lm = 32'hFF00_FF00;
               default: lm = $urandom;
            endcase
         end
         bus.ifu_req_valid  = ip;
         bus.ifu_req_addr   = ia;
         bus.lsu_req_valid  = lp;
         bus.lsu_req_wen    = lwen;
         bus.lsu_req_addr   = la;
         bus.lsu_req_wmask  = lm;
         bus.lsu_req_wdata  = ld;
         bus.ifu_resp_ready = ($urandom_range(0, 3) != 0);
         bus.lsu_resp_ready = ($urandom_range(0, 3) != 0);
         #3;
         if (!busy) begin
            g_vld = ip | lp;
            g = (ip && lp) ? ~m_last : lp;
            chk("rnd_ifu_ready", bus.ifu_req_ready, g_vld && g == GNT_IFU);
            chk("rnd_lsu_ready", bus.lsu_req_ready, g_vld && g == GNT_LSU);
            chk("rnd_idle_rvalid", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
            if (g_vld) begin
               if (g == GNT_LSU && lwen) begin
                  chk("rnd_st_wen", bus.mem_wen, 1);
                  chk("rnd_st_ren", bus.mem_ren, 0);
                  chk("rnd_st_waddr", bus.mem_waddr, la);
                  chk("rnd_st_wmask", bus.mem_wmask, lm);
                  chk("rnd_st_wdata", bus.mem_wdata, ld);
                  mdl[la[7:2]] = (mdl_rd(la) & ~lm) | (ld & lm);
                  mdl_wr[la[7:2]] = 1'b1;
                  exp_data = 0;
               end else begin
                  chk("rnd_rd_ren", bus.mem_ren, 1);
                  chk("rnd_rd_wen", bus.mem_wen, 0);
                  chk("rnd_rd_raddr", bus.mem_raddr, (g == GNT_IFU) ? ia : la);
                  exp_data = mdl_rd((g == GNT_IFU) ? ia : la);
               end
               if (g == GNT_IFU) ip = 0; else lp = 0;
               busy = 1; owner = g; m_last = g;
            end else begin
               chk("rnd_idle_ren", bus.mem_ren, 0);
               chk("rnd_idle_wen", bus.mem_wen, 0);
            end
         end else begin
            chk("rnd_busy_readies", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
            chk("rnd_busy_ren", bus.mem_ren, 0);
            chk("rnd_busy_rvalid", {bus.lsu_resp_valid, bus.ifu_resp_valid},
                (owner == GNT_LSU) ? 2'b10 : 2'b01);
            chk("rnd_busy_rdata",
                (owner == GNT_LSU) ? bus.lsu_resp_rdata : bus.ifu_resp_rdata, exp_data);
            if ((owner == GNT_LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready) busy = 0;
         end
         nxt();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
